// File: rtl/mvu_apb_cmdq.sv
// APB command queue in front of the MVU: two-word commands, FIFO issue, job counters, drain irq.
// Optional watchdog enabled by defining MVU_CMDQ_TIMEOUT_EN.
module mvu_apb_cmdq #(
  parameter int DEPTH       = 8,
  parameter int OUT_W       = 16,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [63:0] cmd_data,
  input  logic        mvu_done,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic        wr_en, rd_en;
  logic [2:0]  addr;
  logic        wr_lo, wr_hi, wr_stat, wr_done, wr_ctrl;

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, cnt;
  logic [63:0]   mem_q [DEPTH];
  logic          empty, full, pop, push, ovf_set;

  logic [31:0]    lo_q, lo_d;
  logic [OUT_W-1:0] out_q, out_d, done_cnt_q, done_cnt_d;
  logic          done_ok, drain_set;
  logic          ovf_q, ovf_d, drain_q, drain_d;
  logic          irq_en_q, irq_en_d, flush_q, flush_d;
  logic          irq_q, irq_d;
  logic          tmo;
  logic [31:0]   prdata_q, prdata_d, status;

  assign wr_en   = psel & penable & pwrite;
  assign rd_en   = psel & ~penable & ~pwrite;
  assign addr    = paddr[4:2];
  assign wr_lo   = wr_en & (addr == 3'd0);
  assign wr_hi   = wr_en & (addr == 3'd1);
  assign wr_stat = wr_en & (addr == 3'd2);
  assign wr_done = wr_en & (addr == 3'd3);
  assign wr_ctrl = wr_en & (addr == 3'd4);

  assign cnt       = wp_q - rp_q;
  assign empty     = (cnt == '0);
  assign full      = (cnt == PW'(DEPTH));
  assign cmd_valid = ~empty & ~flush_q;
  assign cmd_data  = mem_q[rp_q[AW-1:0]];
  assign pop       = cmd_valid & cmd_ready;
  assign push      = wr_hi & ~full & ~flush_q;
  assign ovf_set   = wr_hi & full & ~flush_q;

  assign done_ok   = mvu_done & (out_q != '0);
  assign drain_set = done_ok & (out_q == OUT_W'(1)) & empty;

  logic unused_ok;
  assign unused_ok = ^{paddr[31:5], paddr[1:0], (TIMEOUT_CYC != 0)};

`ifdef MVU_CMDQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;
  logic [WW-1:0] wd_q, wd_d;
  logic          tmo_q, tmo_d, tmo_set;

  assign tmo_set = (out_q != '0) & ~mvu_done &
                   (wd_q == WW'(TIMEOUT_CYC - 1));
  assign tmo     = tmo_q;

  // Watchdog: counts while jobs are outstanding, parks at the limit.
  always_comb begin
    wd_d  = wd_q;
    tmo_d = tmo_set | (tmo_q & ~(wr_stat & pwdata[12]));
    if (mvu_done || out_q == '0)
      wd_d = '0;
    else if (wd_q != WW'(TIMEOUT_CYC - 1))
      wd_d = wd_q + 1'b1;
  end

  // Watchdog state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign status = {19'b0, tmo, drain_q, ovf_q, full, empty, 8'(cnt)};

  // Queue pointers, counters, sticky bits and register read mux.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush_q) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
    end

    lo_d = wr_lo ? pwdata : lo_q;

    out_d = out_q;
    unique case ({pop, done_ok})
      2'b10:   if (out_q != '1) out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    done_cnt_d = done_cnt_q;
    if (wr_done)
      done_cnt_d = '0;
    else if (done_ok && done_cnt_q != '1)
      done_cnt_d = done_cnt_q + 1'b1;

    ovf_d   = ovf_set | (ovf_q & ~(wr_stat & pwdata[10]));
    drain_d = drain_set | (drain_q & ~(wr_stat & pwdata[11]));

    irq_en_d = wr_ctrl ? pwdata[0] : irq_en_q;
    flush_d  = wr_ctrl & pwdata[1];
    irq_d    = irq_en_q & (drain_q | tmo);

    prdata_d = prdata_q;
    if (rd_en) begin
      unique case (addr)
        3'd2:    prdata_d = status;
        3'd3:    prdata_d = 32'(done_cnt_q);
        3'd4:    prdata_d = {31'b0, irq_en_q};
        default: prdata_d = '0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      lo_q       <= '0;
      out_q      <= '0;
      done_cnt_q <= '0;
      ovf_q      <= 1'b0;
      drain_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      flush_q    <= 1'b0;
      irq_q      <= 1'b0;
      prdata_q   <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      lo_q       <= lo_d;
      out_q      <= out_d;
      done_cnt_q <= done_cnt_d;
      ovf_q      <= ovf_d;
      drain_q    <= drain_d;
      irq_en_q   <= irq_en_d;
      flush_q    <= flush_d;
      irq_q      <= irq_d;
      prdata_q   <= prdata_d;
    end
  end

  // FIFO storage, written on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wp_q[AW-1:0]] <= {pwdata, lo_q};
    end
  end

  assign prdata = prdata_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_mvu_apb_cmdq.sv
// Directed bench for mvu_apb_cmdq.
// Expected values are hand-derived; timeout expectations follow MVU_CMDQ_TIMEOUT_EN.
module tb_mvu_apb_cmdq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [63:0] cmd_data;
  logic        mvu_done = 1'b0;
  logic        irq;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] rd;
  logic [31:0] tmo_bit;
  logic        tmo_irq;

  mvu_apb_cmdq #(.DEPTH(8), .OUT_W(16), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .mvu_done(mvu_done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk) #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk) #1;
    penable = 1'b1;
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk) #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk) #1;
    penable = 1'b1;
    d = prdata;
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] lo, input logic [31:0] hi);
    apb_wr(32'h00, lo);
    apb_wr(32'h04, hi);
  endtask

  task automatic pop_n(input int n);
    @(posedge clk) #1;
    cmd_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1 cmd_ready = 1'b0;
  endtask

  task automatic done_pulse();
    @(posedge clk) #1;
    mvu_done = 1'b1;
    @(posedge clk) #1;
    mvu_done = 1'b0;
  endtask

  initial begin
`ifdef MVU_CMDQ_TIMEOUT_EN
    tmo_bit = 32'h1000;
    tmo_irq = 1'b1;
`else
    tmo_bit = 32'h0;
    tmo_irq = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_prdata", 64'(prdata), 64'd0);
    chk("rst_data", cmd_data, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    apb_rd(32'h08, rd);
    chk("rst_status", 64'(rd), 64'h100);

    // single push / issue
    push_cmd(32'h11223344, 32'hA5A50001);
    chk("push_valid", 64'(cmd_valid), 64'd1);
    chk("push_data", cmd_data, 64'hA5A50001_11223344);
    apb_rd(32'h08, rd);
    chk("push_status", 64'(rd), 64'h001);
    repeat (4) @(posedge clk);
    #1 chk("push_hold", cmd_data, 64'hA5A50001_11223344);
    pop_n(1);
    chk("pop_valid", 64'(cmd_valid), 64'd0);
    apb_rd(32'h08, rd);
    chk("pop_status", 64'(rd), 64'h100);
    done_pulse();
    apb_rd(32'h0C, rd);
    chk("done1", 64'(rd), 64'd1);
    apb_wr(32'h08, 32'h1C00);
    apb_wr(32'h0C, 32'h0);
    apb_rd(32'h08, rd);
    chk("clr_status", 64'(rd), 64'h100 | 64'(tmo_bit & 32'h0));

    // overflow
    for (int i = 0; i < 9; i++) push_cmd(32'(i), 32'h100 + 32'(i));
    apb_rd(32'h08, rd);
    chk("ovf_status", 64'(rd), 64'h608);
    @(posedge clk) #1;
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_v%0d", i), 64'(cmd_valid), 64'd1);
      chk($sformatf("drain_d%0d", i), cmd_data,
          {32'h100 + 32'(i), 32'(i)});
      @(posedge clk) #1;
    end
    cmd_ready = 1'b0;
    chk("drain_empty", 64'(cmd_valid), 64'd0);
    for (int i = 0; i < 8; i++) done_pulse();
    apb_rd(32'h0C, rd);
    chk("done8", 64'(rd), 64'd8);
    apb_rd(32'h08, rd);
    chk("ovf_drain_st", 64'(rd), 64'hD00);
    apb_wr(32'h08, 32'h1C00);
    apb_wr(32'h0C, 32'h0);
    apb_rd(32'h08, rd);
    chk("ovf_clr_st", 64'(rd), 64'h100);

    // drain interrupt
    apb_wr(32'h10, 32'h1);
    push_cmd(32'h1, 32'h2);
    push_cmd(32'h3, 32'h4);
    pop_n(2);
    done_pulse();
    chk("irq_pre", 64'(irq), 64'd0);
    done_pulse();
    chk("irq_lat0", 64'(irq), 64'd0);
    @(posedge clk) #1;
    chk("irq_lat1", 64'(irq), 64'd1);
    apb_rd(32'h0C, rd);
    chk("drain_done2", 64'(rd), 64'd2);
    apb_rd(32'h08, rd);
    chk("drain_st", 64'(rd), 64'h900);
    apb_wr(32'h08, 32'h800);
    @(posedge clk) #1;
    chk("irq_clr", 64'(irq), 64'd0);
    apb_wr(32'h0C, 32'h0);

    // pop and done together, then spurious done
    push_cmd(32'hA, 32'hB);
    pop_n(1);
    push_cmd(32'hC, 32'hD);
    @(posedge clk) #1;
    cmd_ready = 1'b1; mvu_done = 1'b1;
    @(posedge clk) #1;
    cmd_ready = 1'b0; mvu_done = 1'b0;
    apb_rd(32'h0C, rd);
    chk("sim_done1", 64'(rd), 64'd1);
    done_pulse();
    apb_rd(32'h0C, rd);
    chk("sim_done2", 64'(rd), 64'd2);
    apb_rd(32'h08, rd);
    chk("sim_st", 64'(rd), 64'h900);
    done_pulse();
    apb_rd(32'h0C, rd);
    chk("spur_done", 64'(rd), 64'd2);
    apb_wr(32'h08, 32'h1C00);
    apb_wr(32'h0C, 32'h0);

    // flush with a push landing in the flush cycle
    push_cmd(32'h5, 32'h6);
    push_cmd(32'h7, 32'h8);
    @(posedge clk) #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'h3;
    @(posedge clk) #1;
    penable = 1'b1;
    @(posedge clk) #1;
    paddr = 32'h04; pwdata = 32'hDEAD;
    chk("flush_valid", 64'(cmd_valid), 64'd0);
    @(posedge clk) #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("flush_after", 64'(cmd_valid), 64'd0);
    apb_rd(32'h08, rd);
    chk("flush_st", 64'(rd), 64'h100);
    apb_rd(32'h10, rd);
    chk("ctrl_rd", 64'(rd), 64'd1);

    // watchdog
    push_cmd(32'h9, 32'hE);
    pop_n(1);
    repeat (20) @(posedge clk);
    apb_rd(32'h08, rd);
    chk("tmo_st", 64'(rd), 64'(32'h100 | tmo_bit));
    chk("tmo_irq", 64'(irq), 64'(tmo_irq));
    done_pulse();
    @(posedge clk) #1;
    chk("pre_rst_irq", 64'(irq), 64'd1);

    // reset mid-operation
    for (int i = 0; i < 3; i++) push_cmd(32'(i), 32'(i));
    apb_rd(32'h08, rd);
    chk("pre_rst_st", 64'(rd), 64'(32'h803 | tmo_bit));
    @(posedge clk) #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(cmd_valid), 64'd0);
    chk("arst_irq", 64'(irq), 64'd0);
    chk("arst_prdata", 64'(prdata), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    apb_rd(32'h08, rd);
    chk("arst_st", 64'(rd), 64'h100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
